// File: rtl/axil2apb_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB4 bridge.
package apb_pkg;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } bridge_state_t;

    function automatic logic inWindow(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/axil2apb_bridge_if.sv
// AXI4-Lite slave side and APB4 master side signals of the bridge.
interface axil2apb_bridge_if;

    logic        in_awvalid, in_awready;
    logic [31:0] in_awaddr;
    logic [2:0]  in_awprot;
    logic        in_wvalid, in_wready;
    logic [31:0] in_wdata;
    logic [3:0]  in_wstrb;
    logic        in_bvalid, in_bready;
    logic [1:0]  in_bresp;
    logic        in_arvalid, in_arready;
    logic [31:0] in_araddr;
    logic [2:0]  in_arprot;
    logic        in_rvalid, in_rready;
    logic [31:0] in_rdata;
    logic [1:0]  in_rresp;

    logic [31:0] out_paddr;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_psel, out_penable;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    // The bridge itself uses the slave view.
    modport slave (
        input  in_awvalid, in_awaddr, in_awprot, in_wvalid, in_wdata, in_wstrb,
        input  in_bready, in_arvalid, in_araddr, in_arprot, in_rready,
        output in_awready, in_wready, in_bvalid, in_bresp,
        output in_arready, in_rvalid, in_rdata, in_rresp,
        output out_paddr, out_pprot, out_pwrite, out_pwdata, out_pstrb,
        output out_psel, out_penable,
        input  out_pready, out_prdata, out_pslverr
    );

    modport master (
        output in_awvalid, in_awaddr, in_awprot, in_wvalid, in_wdata, in_wstrb,
        output in_bready, in_arvalid, in_araddr, in_arprot, in_rready,
        input  in_awready, in_wready, in_bvalid, in_bresp,
        input  in_arready, in_rvalid, in_rdata, in_rresp,
        input  out_paddr, out_pprot, out_pwrite, out_pwdata, out_pstrb,
        input  out_psel, out_penable,
        output out_pready, out_prdata, out_pslverr
    );

endinterface

// File: rtl/axil2apb_bridge.sv
// Single-outstanding AXI4-Lite to APB4 bridge; out-of-window requests answer DECERR locally.
module axil2apb_bridge
    import apb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h1000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hF000_0000
) (
    input  logic             clock,
    input  logic             reset,
    axil2apb_bridge_if.slave bus
);

    bridge_state_t state_q, state_d;
    logic        lastWasWrite_q, lastWasWrite_d;
    logic        isWrite_q, isWrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [2:0]  pprot_q, pprot_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;

    logic        wrEligible, rdEligible, grantRead, grantWrite;
    logic        awReady, arReady;
    logic [31:0] reqAddr;
    logic [2:0]  reqProt;

    // Round-robin: a read wins a tie unless the previous grant was also a read.
    assign wrEligible = bus.in_awvalid && bus.in_wvalid;
    assign rdEligible = bus.in_arvalid;
    assign grantRead  = rdEligible && (!wrEligible || lastWasWrite_q);
    assign grantWrite = wrEligible && !grantRead;
    assign reqAddr    = grantWrite ? bus.in_awaddr : bus.in_araddr;
    assign reqProt    = grantWrite ? bus.in_awprot : bus.in_arprot;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            lastWasWrite_q <= 1'b1;
            isWrite_q      <= 1'b0;
            paddr_q        <= '0;
            pprot_q        <= '0;
            pwrite_q       <= 1'b0;
            pwdata_q       <= '0;
            pstrb_q        <= '0;
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            resp_q         <= AXI_OKAY;
            rdata_q        <= '0;
            bvalid_q       <= 1'b0;
            rvalid_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            lastWasWrite_q <= lastWasWrite_d;
            isWrite_q      <= isWrite_d;
            paddr_q        <= paddr_d;
            pprot_q        <= pprot_d;
            pwrite_q       <= pwrite_d;
            pwdata_q       <= pwdata_d;
            pstrb_q        <= pstrb_d;
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            resp_q         <= resp_d;
            rdata_q        <= rdata_d;
            bvalid_q       <= bvalid_d;
            rvalid_q       <= rvalid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        lastWasWrite_d = lastWasWrite_q;
        isWrite_d      = isWrite_q;
        paddr_d        = paddr_q;
        pprot_d        = pprot_q;
        pwrite_d       = pwrite_q;
        pwdata_d       = pwdata_q;
        pstrb_d        = pstrb_q;
        psel_d         = psel_q;
        penable_d      = penable_q;
        resp_d         = resp_q;
        rdata_d        = rdata_q;
        bvalid_d       = bvalid_q;
        rvalid_d       = rvalid_q;
        awReady        = 1'b0;
        arReady        = 1'b0;
        unique case (state_q)
            IDLE: begin
                awReady = grantWrite;
                arReady = grantRead;
                if (grantRead || grantWrite) begin
                    lastWasWrite_d = grantWrite;
                    isWrite_d      = grantWrite;
                    // APB outputs only move for in-window requests so they hold while psel is low.
                    if (inWindow(reqAddr, ADDR_BASE, ADDR_MASK)) begin
                        paddr_d  = reqAddr;
                        pprot_d  = reqProt;
                        pwrite_d = grantWrite;
                        pwdata_d = grantWrite ? bus.in_wdata : 32'h0;
                        pstrb_d  = grantWrite ? bus.in_wstrb : 4'h0;
                        psel_d   = 1'b1;
                        state_d  = SETUP;
                    end else begin
                        resp_d   = AXI_DECERR;
                        bvalid_d = grantWrite;
                        rvalid_d = !grantWrite;
                        state_d  = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.out_pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    resp_d    = bus.out_pslverr ? AXI_SLVERR : AXI_OKAY;
                    if (!isWrite_q) rdata_d = bus.out_prdata;
                    bvalid_d  = isWrite_q;
                    rvalid_d  = !isWrite_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if ((bvalid_q && bus.in_bready) || (rvalid_q && bus.in_rready)) begin
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Readies are combinational, so they are masked while reset is held.
    assign bus.in_awready  = awReady && !reset;
    assign bus.in_wready   = awReady && !reset;
    assign bus.in_arready  = arReady && !reset;
    assign bus.in_bvalid   = bvalid_q;
    assign bus.in_bresp    = resp_q;
    assign bus.in_rvalid   = rvalid_q;
    assign bus.in_rdata    = rdata_q;
    assign bus.in_rresp    = resp_q;
    assign bus.out_paddr   = paddr_q;
    assign bus.out_pprot   = pprot_q;
    assign bus.out_pwrite  = pwrite_q;
    assign bus.out_pwdata  = pwdata_q;
    assign bus.out_pstrb   = pstrb_q;
    assign bus.out_psel    = psel_q;
    assign bus.out_penable = penable_q;

endmodule

// File: tb/tb_axil2apb_bridge.sv
// Scoreboard bench for axil2apb_bridge with a behavioural APB slave.
module tb_axil2apb_bridge;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;
    int   pselCnt;
    int   penCnt;
    int   apbWait;
    logic [31:0] apbRdata;
    logic        apbErr;

    typedef struct {
        logic        isWr;
        logic [1:0]  resp;
        logic [31:0] data;
        logic        chkData;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } apb_t;

    rsp_t rspQ[$];
    apb_t apbQ[$];

    axil2apb_bridge_if bus();

    axil2apb_bridge #(
        .ADDR_BASE(32'h1000_0000),
        .ADDR_MASK(32'hF000_0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural APB slave: pready after apbWait ACCESS cycles.
    initial begin : apbSlave
        int accCnt;
        accCnt = 0;
        bus.out_pready  = 1'b0;
        bus.out_prdata  = 32'h0;
        bus.out_pslverr = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (reset || !(bus.out_psel && bus.out_penable)) begin
                bus.out_pready = 1'b0;
                accCnt = 0;
            end else begin
                if (accCnt == apbWait) begin
                    bus.out_pready  = 1'b1;
                    bus.out_prdata  = apbRdata;
                    bus.out_pslverr = apbErr;
                end
                accCnt++;
            end
        end
    end

    // Response monitor: pops one expectation per B or R handshake.
    always @(negedge clock) begin
        if (!reset && ((bus.in_bvalid && bus.in_bready) || (bus.in_rvalid && bus.in_rready))) begin
            check("rsp_expected", rspQ.size() != 0, 1'b1);
            if (rspQ.size() != 0) begin
                rsp_t e;
                e = rspQ.pop_front();
                check("rsp_type", bus.in_bvalid, e.isWr);
                check("rsp_code", e.isWr ? bus.in_bresp : bus.in_rresp, e.resp);
                if (e.chkData && !e.isWr) check("rsp_rdata", bus.in_rdata, e.data);
            end
        end
    end

    // APB request monitor: checks the SETUP phase contents and counts phases.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.out_psel) pselCnt++;
            if (bus.out_psel && bus.out_penable) penCnt++;
            if (bus.out_psel && !bus.out_penable) begin
                check("apb_expected", apbQ.size() != 0, 1'b1);
                if (apbQ.size() != 0) begin
                    apb_t a;
                    a = apbQ.pop_front();
                    check("apb_req", {bus.out_paddr, bus.out_pwrite, bus.out_pwdata, bus.out_pstrb, bus.out_pprot},
                          {a.addr, a.wr, a.wdata, a.strb, a.prot});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkAllZero(input string name);
        check({name, "_axi"}, {bus.in_awready, bus.in_wready, bus.in_bvalid, bus.in_bresp, bus.in_arready,
                               bus.in_rvalid, bus.in_rdata, bus.in_rresp}, '0);
        check({name, "_apb"}, {bus.out_paddr, bus.out_pprot, bus.out_pwrite, bus.out_pwdata, bus.out_pstrb,
                               bus.out_psel, bus.out_penable}, '0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic waitAccept(input logic isWr);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            got = isWr ? (bus.in_awready && bus.in_wready) : bus.in_arready;
        end
        check(isWr ? "accept_wr" : "accept_rd", got, 1'b1);
        tick();
    endtask

    task automatic applyStimulusWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                      input logic [1:0] resp, input logic inWin);
        rspQ.push_back('{1'b1, resp, 32'h0, 1'b0});
        if (inWin) apbQ.push_back('{a, 1'b1, d, s, 3'b010});
        bus.in_awaddr  = a;
        bus.in_awprot  = 3'b010;
        bus.in_wdata   = d;
        bus.in_wstrb   = s;
        bus.in_awvalid = 1'b1;
        bus.in_wvalid  = 1'b1;
        waitAccept(1'b1);
        bus.in_awvalid = 1'b0;
        bus.in_wvalid  = 1'b0;
    endtask

    task automatic applyStimulusRead(input logic [31:0] a, input logic [1:0] resp, input logic [31:0] d,
                                     input logic inWin, input logic expectRsp);
        if (expectRsp) rspQ.push_back('{1'b0, resp, d, inWin});
        if (inWin) apbQ.push_back('{a, 1'b0, 32'h0, 4'h0, 3'b001});
        bus.in_araddr  = a;
        bus.in_arprot  = 3'b001;
        bus.in_arvalid = 1'b1;
        waitAccept(1'b0);
        bus.in_arvalid = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        for (int n = 0; n < 100 && rspQ.size() != 0; n++) @(negedge clock);
        check(name, rspQ.size(), 0);
        tick();
    endtask

    initial begin
        int p0;
        int acc;
        logic stable;
        checks = 0; failures = 0; cyc = 0; pselCnt = 0; penCnt = 0;
        apbWait = 0; apbRdata = 32'h0; apbErr = 1'b0;
        reset = 1'b1;
        bus.in_awvalid = 0; bus.in_awaddr = 0; bus.in_awprot = 0;
        bus.in_wvalid = 0; bus.in_wdata = 0; bus.in_wstrb = 0; bus.in_bready = 1;
        bus.in_arvalid = 0; bus.in_araddr = 0; bus.in_arprot = 0; bus.in_rready = 1;

        repeat (2) @(negedge clock);
        checkAllZero("reset_state");
        reset = 1'b0;
        tick();

        // Write with pready in the first ACCESS cycle, latency checked cycle by cycle.
        applyStimulusWrite(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b1);
        @(negedge clock);
        check("wr_lat_setup", {bus.out_psel, bus.out_penable, bus.out_pwrite, bus.out_pstrb}, {3'b101, 4'hF});
        @(negedge clock);
        check("wr_lat_access", {bus.out_psel, bus.out_penable, bus.in_bvalid}, 3'b110);
        @(negedge clock);
        check("wr_lat_bvalid", {bus.out_psel, bus.out_penable, bus.in_bvalid, bus.in_bresp}, 5'b00100);
        checkOutput("wr_done");

        // Read with four wait states.
        apbWait = 4; apbRdata = 32'h1234_5678;
        p0 = penCnt;
        applyStimulusRead(32'h1000_0008, 2'b00, 32'h1234_5678, 1'b1, 1'b1);
        checkOutput("rd_wait_done");
        check("rd_wait_penable", penCnt - p0, 5);

        // Slave errors on both directions.
        apbWait = 1; apbErr = 1'b1; apbRdata = 32'hCAFE_0000;
        applyStimulusRead(32'h1000_000C, 2'b10, 32'hCAFE_0000, 1'b1, 1'b1);
        checkOutput("rd_err_done");
        applyStimulusWrite(32'h1FFF_FFFC, 32'h0000_00A5, 4'h1, 2'b10, 1'b1);
        checkOutput("wr_err_done");
        apbWait = 0; apbErr = 1'b0;

        // Out-of-window requests never touch APB.
        p0 = pselCnt;
        applyStimulusRead(32'h2000_0000, 2'b11, 32'h0, 1'b0, 1'b1);
        @(negedge clock);
        check("decerr_rd_lat", {bus.in_rvalid, bus.in_rresp}, 3'b111);
        checkOutput("decerr_rd_done");
        applyStimulusWrite(32'h0000_0100, 32'h5555_AAAA, 4'hC, 2'b11, 1'b0);
        checkOutput("decerr_wr_done");
        check("decerr_no_psel", pselCnt - p0, 0);

        // AW without W must not be accepted.
        bus.in_awaddr = 32'h1000_0040; bus.in_awvalid = 1'b1; bus.in_wvalid = 1'b0;
        stable = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (bus.in_awready || bus.in_wready) stable = 1'b0;
        end
        check("aw_needs_w", stable, 1'b1);
        tick();
        bus.in_awvalid = 1'b0;
        applyStimulusWrite(32'h1000_0040, 32'h0BAD_F00D, 4'h6, 2'b00, 1'b1);
        checkOutput("aw_w_done");

        // All requests held high after reset: read, write, read, write.
        doReset();
        apbRdata = 32'hA5A5_0001;
        rspQ.push_back('{1'b0, 2'b00, 32'hA5A5_0001, 1'b1});
        rspQ.push_back('{1'b1, 2'b00, 32'h0, 1'b0});
        rspQ.push_back('{1'b0, 2'b00, 32'hA5A5_0001, 1'b1});
        rspQ.push_back('{1'b1, 2'b00, 32'h0, 1'b0});
        for (int i = 0; i < 2; i++) begin
            apbQ.push_back('{32'h1000_0010, 1'b0, 32'h0, 4'h0, 3'b001});
            apbQ.push_back('{32'h1000_0020, 1'b1, 32'h1111_2222, 4'h3, 3'b010});
        end
        bus.in_araddr = 32'h1000_0010; bus.in_arprot = 3'b001;
        bus.in_awaddr = 32'h1000_0020; bus.in_awprot = 3'b010;
        bus.in_wdata = 32'h1111_2222; bus.in_wstrb = 4'h3;
        bus.in_arvalid = 1'b1; bus.in_awvalid = 1'b1; bus.in_wvalid = 1'b1;
        acc = 0;
        for (int n = 0; n < 200 && acc < 4; n++) begin
            @(negedge clock);
            if (bus.in_arready || (bus.in_awready && bus.in_wready)) acc++;
        end
        check("rr_accepts", acc, 4);
        tick();
        bus.in_arvalid = 1'b0; bus.in_awvalid = 1'b0; bus.in_wvalid = 1'b0;
        checkOutput("rr_done");

        // Stalled B channel: response held and nothing new accepted.
        bus.in_bready = 1'b0;
        applyStimulusWrite(32'h1000_0050, 32'h7777_8888, 4'hF, 2'b00, 1'b1);
        for (int n = 0; n < 20 && !bus.in_bvalid; n++) @(negedge clock);
        bus.in_araddr = 32'h1000_0054; bus.in_arvalid = 1'b1;
        stable = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (!bus.in_bvalid || bus.in_bresp != 2'b00 || bus.in_arready) stable = 1'b0;
        end
        check("bready_hold", stable, 1'b1);
        tick();
        bus.in_bready = 1'b1;
        @(negedge clock);
        check("handshake_no_accept", {bus.in_bvalid, bus.in_arready}, 2'b10);
        bus.in_arvalid = 1'b0;
        checkOutput("bready_done");

        // Reset in the middle of ACCESS drops the transfer silently.
        apbWait = 10;
        applyStimulusRead(32'h1000_0030, 2'b00, 32'h0, 1'b1, 1'b0);
        for (int n = 0; n < 20 && !bus.out_penable; n++) @(negedge clock);
        @(negedge clock);
        check("mid_access", bus.out_penable, 1'b1);
        reset = 1'b1;
        #1;
        checkAllZero("reset_mid");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        apbWait = 0;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (bus.out_psel || bus.in_bvalid || bus.in_rvalid) stable = 1'b0;
        end
        check("idle_after_reset", stable, 1'b1);
        tick();
        apbRdata = 32'h0F0F_1234;
        applyStimulusRead(32'h1000_0060, 2'b00, 32'h0F0F_1234, 1'b1, 1'b1);
        checkOutput("post_reset_rd");

        check("apb_queue_empty", apbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
